palette_ram_cycler: RTL and testbench

//  Multi-palette colour lookup for the sprite/tile renderer: NUM_PAL writable palettes of 2**IDX_W RGB entries.

---
 rtl/palette_ram_cycler_pkg.sv | 28 ++
 rtl/palette_cycle_remap.sv | 35 +++
 rtl/palette_ram_cycler.sv | 210 +++++++++++++++++++++
 tb/tb_palette_ram_cycler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_ram_cycler_pkg.sv
// Shared types and power-up colour table for the palette RAM / colour-cycling block.
package palette_pkg;

  localparam int PKG_COLOR_W   = 4;
  localparam int DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic [PKG_COLOR_W-1:0] r;
    logic [PKG_COLOR_W-1:0] g;
    logic [PKG_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } fsm_e;

  localparam rgb_t DEFAULT_PAL [DEFAULT_DEPTH] = '{
    rgb_t'(12'h000), rgb_t'(12'hF00), rgb_t'(12'h0F0), rgb_t'(12'h00F),
    rgb_t'(12'hFF0), rgb_t'(12'h0FF), rgb_t'(12'hF0F), rgb_t'(12'hFFF)
  };

  // Deeper palettes repeat the default table.
  function automatic rgb_t default_rgb(input int unsigned e);
    return DEFAULT_PAL[e % DEFAULT_DEPTH];
  endfunction

endpackage

// File: rtl/palette_cycle_remap.sv
// Combinational colour-cycling index remap: rotates indices inside [lo,hi] by off.
module palette_cycle_remap #(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] lo,
  input  logic [IDX_W-1:0] hi,
  input  logic [IDX_W-1:0] off,
  input  logic             active,
  output logic [IDX_W-1:0] eff_idx
);

  localparam logic [IDX_W:0] ONE_X = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0] span_s;
  logic [IDX_W:0] rel_s;
  logic [IDX_W:0] wrap_s;

  // Offset inside the range, wrapped once by the span
  always_comb begin
    span_s = {1'b0, hi} - {1'b0, lo} + ONE_X;
    rel_s  = {1'b0, idx} - {1'b0, lo} + {1'b0, off};
    if (rel_s >= span_s) begin
      wrap_s = rel_s - span_s;
    end else begin
      wrap_s = rel_s;
    end
    if (active && (idx >= lo) && (idx <= hi)) begin
      eff_idx = lo + wrap_s[IDX_W-1:0];
    end else begin
      eff_idx = idx;
    end
  end

endmodule

// File: rtl/palette_ram_cycler.sv
// Multi-palette colour lookup with default fill, loader write port, colour cycling
// and a 2-stage registered read path.
module palette_ram_cycler
  import palette_pkg::*;
#(
  parameter  int IDX_W   = 3,
  parameter  int NUM_PAL = 4,
  parameter  int COLOR_W = 4,
  localparam int PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
  localparam int DEPTH   = 2 ** IDX_W,
  localparam int ENTRY_W = 3 * COLOR_W,
  localparam int ADDR_W  = PAL_W + IDX_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [PAL_W-1:0]   wr_pal,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ENTRY_W-1:0] wr_rgb,
  input  logic               rd_valid,
  input  logic [PAL_W-1:0]   rd_pal,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               out_valid,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  input  logic               frame_tick,
  input  logic               cyc_en,
  input  logic [IDX_W-1:0]   cyc_lo,
  input  logic [IDX_W-1:0]   cyc_hi,
  output logic               init_done
);

  localparam logic [PAL_W:0]    NUM_PAL_V = (PAL_W + 1)'(NUM_PAL);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(NUM_PAL * DEPTH - 1);
  localparam logic [IDX_W:0]    ONE_X     = {{IDX_W{1'b0}}, 1'b1};

  fsm_e                state_r, state_s;
  logic [ADDR_W-1:0]   fill_r;
  logic                init_done_r, wr_ready_r;
  logic                we_s, wp_we_r;
  logic [ADDR_W-1:0]   waddr_s, wp_addr_r;
  logic [ENTRY_W-1:0]  wdata_s, wp_data_r;
  logic [ENTRY_W-1:0]  mem_r [2**ADDR_W];
  logic [IDX_W:0]      span_s;
  logic                active_s;
  logic [IDX_W-1:0]    cyc_off_r, eff_s;
  logic                s1_valid_r, s1_pal_ok_r;
  logic [ADDR_W-1:0]   s1_addr_r;
  logic                out_valid_r;
  logic [ENTRY_W-1:0]  rgb_r;

  // FSM state register and fill counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= INIT;
      fill_r  <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == INIT) begin
        fill_r <= fill_r + ADDR_W'(1);
      end else begin
        fill_r <= fill_r;
      end
    end
  end

  // FSM next state: INIT walks every {pal,idx}, IDLE is terminal
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (fill_r == FILL_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = INIT;
        end
      end
      IDLE:    state_s = IDLE;
      default: state_s = INIT;
    endcase
  end

  // FSM outputs: the single RAM write port serves the fill and the loader
  always_comb begin
    we_s    = 1'b0;
    waddr_s = '0;
    wdata_s = '0;
    case (state_r)
      INIT: begin
        we_s    = 1'b1;
        waddr_s = fill_r;
        wdata_s = ENTRY_W'(default_rgb(32'(fill_r[IDX_W-1:0])));
      end
      IDLE: begin
        we_s    = wr_valid && ({1'b0, wr_pal} < NUM_PAL_V);
        waddr_s = {wr_pal, wr_idx};
        wdata_s = wr_rgb;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Status flags registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done_r <= 1'b0;
      wr_ready_r  <= 1'b0;
    end else begin
      init_done_r <= (state_s == IDLE);
      wr_ready_r  <= (state_s == IDLE);
    end
  end

  // Write staging: commit lands on the same edge as S2 of a same-cycle read, giving read-first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_we_r   <= 1'b0;
      wp_addr_r <= '0;
      wp_data_r <= '0;
    end else begin
      wp_we_r   <= we_s;
      wp_addr_r <= waddr_s;
      wp_data_r <= wdata_s;
    end
  end

  // Palette storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (wp_we_r) begin
      mem_r[wp_addr_r] <= wp_data_r;
    end
  end

  // Cycling is live only for a well-formed range of at least two entries
  always_comb begin
    span_s   = {1'b0, cyc_hi} - {1'b0, cyc_lo} + ONE_X;
    active_s = cyc_en && (cyc_hi >= cyc_lo) && (span_s > ONE_X);
  end

  // Animation offset, advanced once per frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_off_r <= '0;
    end else if (!cyc_en) begin
      cyc_off_r <= '0;
    end else if (frame_tick && active_s) begin
      if (({1'b0, cyc_off_r} + ONE_X) >= span_s) begin
        cyc_off_r <= '0;
      end else begin
        cyc_off_r <= cyc_off_r + IDX_W'(1);
      end
    end else begin
      cyc_off_r <= cyc_off_r;
    end
  end

  palette_cycle_remap #(.IDX_W(IDX_W)) u_remap (
    .idx     (rd_idx),
    .lo      (cyc_lo),
    .hi      (cyc_hi),
    .off     (cyc_off_r),
    .active  (active_s),
    .eff_idx (eff_s)
  );

  // Read stage 1: remapped address and palette range check
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r  <= 1'b0;
      s1_addr_r   <= '0;
      s1_pal_ok_r <= 1'b0;
    end else begin
      s1_valid_r <= rd_valid;
      if (rd_valid) begin
        s1_addr_r   <= {rd_pal, eff_s};
        s1_pal_ok_r <= ({1'b0, rd_pal} < NUM_PAL_V);
      end else begin
        s1_addr_r   <= s1_addr_r;
        s1_pal_ok_r <= s1_pal_ok_r;
      end
    end
  end

  // Read stage 2: RAM data to colour outputs, held while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      rgb_r       <= '0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        rgb_r <= s1_pal_ok_r ? mem_r[s1_addr_r] : '0;
      end else begin
        rgb_r <= rgb_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign red       = rgb_r[ENTRY_W-1 -: COLOR_W];
  assign green     = rgb_r[2*COLOR_W-1 -: COLOR_W];
  assign blue      = rgb_r[COLOR_W-1:0];
  assign wr_ready  = wr_ready_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_palette_ram_cycler.sv
// Self-checking bench for palette_ram_cycler: directed tables, corner sequences and a random run.
module tb_palette_ram_cycler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_valid = 1'b0, rd_valid = 1'b0, frame_tick = 1'b0, cyc_en = 1'b0;
  logic [1:0]  wr_pal = 2'd0, rd_pal = 2'd0;
  logic [2:0]  wr_idx = 3'd0, rd_idx = 3'd0, cyc_lo = 3'd0, cyc_hi = 3'd0;
  logic [11:0] wr_rgb = 12'h000;
  logic        wr_ready, out_valid, init_done;
  logic [3:0]  red, green, blue;
  logic [11:0] rgb_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] dflt [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                            12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};

  typedef struct {
    bit          is_wr;
    int          pal;
    int          idx;
    logic [11:0] rgb;
    string       name;
  } vec_t;

  typedef struct {
    bit          v;
    logic [11:0] rgb;
  } exp_t;

  palette_ram_cycler dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_idx(rd_idx),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .frame_tick(frame_tick), .cyc_en(cyc_en), .cyc_lo(cyc_lo), .cyc_hi(cyc_hi),
    .init_done(init_done)
  );

  assign rgb_s = {red, green, blue};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input int pal, input int idx, input logic [11:0] rgb);
    wr_valid = 1'b1; wr_pal = pal[1:0]; wr_idx = idx[2:0]; wr_rgb = rgb;
    step();
    wr_valid = 1'b0;
  endtask

  // One isolated read: no output after one edge, the colour after two.
  task automatic do_read(input string name, input int pal, input int idx, input logic [11:0] exp);
    rd_valid = 1'b1; rd_pal = pal[1:0]; rd_idx = idx[2:0];
    step();
    rd_valid = 1'b0;
    check({name, " early"}, 32'(out_valid), 32'd0);
    step();
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check(name, 32'(rgb_s), 32'(exp));
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic wait_init(input string name);
    for (int i = 0; i < 31; i++) step();
    check({name, " init_done early"}, 32'(init_done), 32'd0);
    check({name, " wr_ready early"}, 32'(wr_ready), 32'd0);
    step();
    check({name, " init_done"}, 32'(init_done), 32'd1);
    check({name, " wr_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    exp_t        q[$];
    exp_t        e;
    logic [11:0] mm [4][8];
    logic [11:0] last_m;
    int          off_m, lo, hi, span, idx, eff, r;
    bit          act;

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        v.is_wr = 1'b0; v.pal = p; v.idx = i; v.rgb = dflt[i];
        v.name = $sformatf("dflt p%0d i%0d", p, i);
        tbl.push_back(v);
      end
    end
    v.is_wr = 1'b1; v.pal = 2; v.idx = 5; v.rgb = 12'hABC; v.name = "wr p2 i5";
    tbl.push_back(v);
    v.is_wr = 1'b0; v.pal = 2; v.idx = 5; v.rgb = 12'hABC; v.name = "rd p2 i5 new";
    tbl.push_back(v);
    v.is_wr = 1'b0; v.pal = 1; v.idx = 5; v.rgb = dflt[5]; v.name = "rd p1 i5 untouched";
    tbl.push_back(v);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst rgb", 32'(rgb_s), 32'd0);
    check("rst wr_ready", 32'(wr_ready), 32'd0);
    check("rst init_done", 32'(init_done), 32'd0);
    reset_n = 1'b1;
    wait_init("init");

    foreach (tbl[k]) begin
      if (tbl[k].is_wr) do_write(tbl[k].pal, tbl[k].idx, tbl[k].rgb);
      else do_read(tbl[k].name, tbl[k].pal, tbl[k].idx, tbl[k].rgb);
    end

    // Same-cycle write and read of one entry: old data, then new
    wr_valid = 1'b1; wr_pal = 2'd0; wr_idx = 3'd3; wr_rgb = 12'h123;
    rd_valid = 1'b1; rd_pal = 2'd0; rd_idx = 3'd3;
    step();
    wr_valid = 1'b0;
    step();
    rd_valid = 1'b0;
    check("read-first old", 32'(rgb_s), 32'(dflt[3]));
    step();
    check("read after write", 32'(rgb_s), 32'h123);
    step();

    // Colour cycling over [2,5]
    cyc_en = 1'b1; cyc_lo = 3'd2; cyc_hi = 3'd5;
    repeat (3) tick();
    do_read("cyc idx2", 1, 2, dflt[5]);
    do_read("cyc idx5", 1, 5, dflt[4]);
    do_read("cyc idx3", 1, 3, dflt[2]);
    do_read("cyc idx1 outside", 1, 1, dflt[1]);
    do_read("cyc idx6 outside", 1, 6, dflt[6]);
    tick();
    do_read("cyc wrap idx2", 1, 2, dflt[2]);

    // Degenerate ranges and enable clear
    tick();
    do_read("cyc off1 idx2", 1, 2, dflt[3]);
    cyc_lo = 3'd6; cyc_hi = 3'd3;
    do_read("inverted range idx2", 1, 2, dflt[2]);
    tick();
    cyc_lo = 3'd2; cyc_hi = 3'd2;
    do_read("single range idx2", 1, 2, dflt[2]);
    tick();
    cyc_lo = 3'd2; cyc_hi = 3'd5;
    do_read("offset kept idx2", 1, 2, dflt[3]);
    cyc_en = 1'b0;
    step();
    cyc_en = 1'b1;
    do_read("cyc_en clear idx2", 1, 2, dflt[2]);
    cyc_en = 1'b0;

    // Asynchronous reset in the middle of a read stream
    rd_valid = 1'b1; rd_pal = 2'd0; rd_idx = 3'd1;
    repeat (3) step();
    check("pre-reset valid", 32'(out_valid), 32'd1);
    check("pre-reset rgb", 32'(rgb_s), 32'(dflt[1]));
    #2 reset_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst rgb", 32'(rgb_s), 32'd0);
    check("async rst wr_ready", 32'(wr_ready), 32'd0);
    check("async rst init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rd_valid = 1'b0;
    step();
    reset_n = 1'b1;
    wait_init("reinit");
    do_read("reinit p0 i3", 0, 3, dflt[3]);
    do_read("reinit p2 i5", 2, 5, dflt[5]);

    // Random traffic against a reference model
    for (int p = 0; p < 4; p++) for (int i = 0; i < 8; i++) mm[p][i] = dflt[i];
    off_m = 0;
    last_m = 12'h000;
    cyc_lo = 3'd1; cyc_hi = 3'd6; cyc_en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      rd_valid   = (k == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      rd_pal     = 2'($urandom_range(0, 3));
      rd_idx     = 3'($urandom_range(0, 7));
      wr_valid   = ($urandom_range(0, 9) < 3);
      wr_pal     = 2'($urandom_range(0, 3));
      wr_idx     = 3'($urandom_range(0, 7));
      wr_rgb     = 12'($urandom);
      frame_tick = ($urandom_range(0, 4) == 0);
      cyc_en     = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) begin
        cyc_lo = 3'($urandom_range(0, 7));
        cyc_hi = 3'($urandom_range(0, 7));
      end
      lo   = int'(cyc_lo);
      hi   = int'(cyc_hi);
      span = hi - lo + 1;
      act  = cyc_en && (hi >= lo) && (span > 1);
      e.v  = rd_valid;
      if (rd_valid) begin
        idx = int'(rd_idx);
        eff = idx;
        if (act && idx >= lo && idx <= hi) begin
          r = idx - lo + off_m;
          if (r >= span) r = r - span;
          eff = (lo + r) % 8;
        end
        last_m = mm[rd_pal][eff];
      end
      e.rgb = last_m;
      q.push_back(e);
      if (wr_valid) mm[wr_pal][wr_idx] = wr_rgb;
      if (!cyc_en) off_m = 0;
      else if (frame_tick && act) off_m = (off_m + 1 >= span) ? 0 : off_m + 1;
      step();
      if (q.size() == 2) begin
        e = q.pop_front();
        check("rand out_valid", 32'(out_valid), 32'(e.v));
        check("rand rgb", 32'(rgb_s), 32'(e.rgb));
      end
    end
    rd_valid = 1'b0; wr_valid = 1'b0; frame_tick = 1'b0;
    step();
    e = q.pop_front();
    check("rand last out_valid", 32'(out_valid), 32'(e.v));
    check("rand last rgb", 32'(rgb_s), 32'(e.rgb));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
